// File: rtl/motion_pkg.sv
// motion_pkg: shared op-codes, FSM state type and default timing for the motion controller
//   DEF_NUM_C / DEF_RAMP_STEP / DEF_MAX_SPEED : default parameter values
//   OP_*                                       : cmd_op encodings (5-7 reserved)
//   state_t                                    : controller FSM states
//   op_dirs()                                  : {dir_l, dir_r} for an op, or current dirs if the op does not steer
package motion_pkg;
    localparam int DEF_NUM_C     = 11000;
    localparam int DEF_RAMP_STEP = 500;
    localparam int DEF_MAX_SPEED = 11000;
    localparam logic [2:0] OP_STOP    = 3'd0;
    localparam logic [2:0] OP_FWD     = 3'd1;
    localparam logic [2:0] OP_REV     = 3'd2;
    localparam logic [2:0] OP_PIVOT_L = 3'd3;
    localparam logic [2:0] OP_PIVOT_R = 3'd4;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECEL,
        ST_ACCEL,
        ST_HOLD,
        ST_STOPPING
    } state_t;
    function automatic logic [1:0] op_dirs(input logic [2:0] op, input logic [1:0] cur);
        return op == OP_FWD     ? 2'b11 :
               op == OP_REV     ? 2'b00 :
               op == OP_PIVOT_L ? 2'b01 :
               op == OP_PIVOT_R ? 2'b10 : cur;
    endfunction
endpackage

// File: rtl/motion_ctrl_period_tick.sv
// period_tick: free-running divider, one-cycle tick every NUM_C clocks
//   clk   : system clock
//   rst_n : asynchronous active-low reset, counter restarts at 0
//   tick  : high while the counter sits at NUM_C-1
module period_tick
    import motion_pkg::*;
#(
    parameter int NUM_C = DEF_NUM_C
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int W = NUM_C > 1 ? $clog2(NUM_C) : 1;
    logic [W-1:0] cnt;
    assign tick = cnt == W'(NUM_C - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/motion_ctrl.sv
// motion_ctrl: command-driven wheel speed/direction controller with tick-paced ramps
//   clk, rst_n        : system clock, asynchronous active-low reset
//   cmd_valid/ready   : command handshake; ready only in IDLE while abort is low
//   cmd_op/speed/dur  : op-code, target speed, hold time in ticks
//   abort             : level; ramps an active command down to zero
//   dir_l/r, speed_l/r: registered drive to the PWM block (speed_l == speed_r)
//   busy              : controller not IDLE
//   done / aborted    : one-cycle completion pulses (normal / aborted)
module motion_ctrl
    import motion_pkg::*;
#(
    parameter int NUM_C     = DEF_NUM_C,
    parameter int RAMP_STEP = DEF_RAMP_STEP,
    parameter int MAX_SPEED = DEF_MAX_SPEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [13:0] cmd_speed,
    input  logic [15:0] cmd_dur,
    input  logic        abort,
    output logic        dir_l,
    output logic        dir_r,
    output logic [13:0] speed_l,
    output logic [13:0] speed_r,
    output logic        busy,
    output logic        done,
    output logic        aborted
);
    state_t      state;
    logic        tick;
    logic        rdy_en;
    logic        abort_seen;
    logic [13:0] speed;
    logic [13:0] target;
    logic [15:0] dur_q;
    logic [15:0] hold_cnt;
    logic [1:0]  dirs;
    logic [1:0]  new_dirs;
    logic        accept;
    logic        cmd_move;
    logic [1:0]  cmd_dirs;
    logic [13:0] cmd_tgt;
    logic [14:0] up_sum;
    logic [13:0] ramp_up;
    logic [13:0] ramp_dn;
    logic [13:0] step_to;

    period_tick #(.NUM_C(NUM_C)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    // rdy_en holds cmd_ready low during reset and releases it on the first edge after
    assign cmd_ready = rdy_en && state == ST_IDLE && !abort;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = state != ST_IDLE;
    assign dir_l     = dirs[1];
    assign dir_r     = dirs[0];
    assign speed_l   = speed;
    assign speed_r   = speed;

    assign cmd_move = cmd_op >= OP_FWD && cmd_op <= OP_PIVOT_R;
    assign cmd_dirs = op_dirs(cmd_op, dirs);
    assign cmd_tgt  = !cmd_move ? '0 : cmd_speed > 14'(MAX_SPEED) ? 14'(MAX_SPEED) : cmd_speed;

    // one ramp step toward target, clamped so it never passes the target
    assign up_sum  = {1'b0, speed} + 15'(RAMP_STEP);
    assign ramp_up = up_sum > {1'b0, target} ? target : up_sum[13:0];
    assign ramp_dn = speed > 14'(RAMP_STEP) ? speed - 14'(RAMP_STEP) : '0;
    assign step_to = speed < target ? ramp_up : ramp_dn < target ? target : ramp_dn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rdy_en     <= 1'b0;
            abort_seen <= 1'b0;
            speed      <= '0;
            target     <= '0;
            dur_q      <= '0;
            hold_cnt   <= '0;
            dirs       <= 2'b11;
            new_dirs   <= 2'b11;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            rdy_en  <= 1'b1;
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        target     <= cmd_tgt;
                        dur_q      <= cmd_move ? cmd_dur : '0;
                        new_dirs   <= cmd_dirs;
                        hold_cnt   <= '0;
                        abort_seen <= 1'b0;
                        if (cmd_dirs != dirs && speed != '0) begin
                            state <= ST_DECEL;
                        end else begin
                            dirs  <= cmd_dirs;
                            state <= ST_ACCEL;
                        end
                    end
                end
                ST_DECEL: begin
                    if (abort) begin
                        abort_seen <= 1'b1;
                        state      <= ST_STOPPING;
                    end else if (tick) begin
                        speed <= ramp_dn;
                        // wheels reverse on the same edge the speed reaches zero
                        if (ramp_dn == '0) begin
                            dirs  <= new_dirs;
                            state <= ST_ACCEL;
                        end
                    end
                end
                ST_ACCEL: begin
                    if (abort) begin
                        abort_seen <= 1'b1;
                        state      <= ST_STOPPING;
                    end else if (speed == target) begin
                        state <= ST_HOLD;
                    end else if (tick) begin
                        speed <= step_to;
                    end
                end
                ST_HOLD: begin
                    if (abort) begin
                        abort_seen <= 1'b1;
                        state      <= ST_STOPPING;
                    end else if (hold_cnt == dur_q) begin
                        state <= ST_STOPPING;
                    end else if (tick) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_STOPPING: begin
                    if (speed == '0) begin
                        state   <= ST_IDLE;
                        done    <= !abort_seen;
                        aborted <= abort_seen;
                    end else if (tick) begin
                        speed <= ramp_dn;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/motion_ctrl.md
MOTION_CTRL -- requirements
Module: motion_ctrl

Interface
REQ-001 Parameter NUM_C, default 11000, clocks per motor PWM period (ramp/duration time base).
REQ-002 Parameter RAMP_STEP, default 500, speed change per tick.
REQ-003 Parameter MAX_SPEED, default 11000, speed clamp value; shall not exceed NUM_C.
REQ-004 clk  input  1  single system clock; all state on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  controller accepts command this cycle.
REQ-008 cmd_op  input  3  0 STOP, 1 FWD, 2 REV, 3 PIVOT_L, 4 PIVOT_R, 5-7 reserved.
REQ-009 cmd_speed  input  14  target speed, compare value for PWM block.
REQ-010 cmd_dur  input  16  hold time in ticks.
REQ-011 abort  input  1  level; forces ramp-down to zero.
REQ-012 dir_l, dir_r  output  1 each  wheel direction to PWM block.
REQ-013 speed_l, speed_r  output  14 each  wheel speed to PWM block.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse, command completed normally.
REQ-016 aborted  output  1  one-cycle pulse, command ended by abort.

Function
REQ-017 tick shall pulse one cycle every NUM_C clocks (free-running counter 0..NUM_C-1, tick at NUM_C-1), counter running from reset release.
REQ-018 Handshake: transfer occurs when cmd_valid and cmd_ready both high; cmd_ready = 1 only in IDLE with abort low.
REQ-019 On accept, op/speed/dur shall be registered; target = min(cmd_speed, MAX_SPEED); reserved ops and STOP shall use target 0, dur 0.
REQ-020 Direction map (dir_l,dir_r): FWD (1,1), REV (0,0), PIVOT_L (0,1), PIVOT_R (1,0); STOP/reserved keep current dirs.
REQ-021 States: IDLE, DECEL, ACCEL, HOLD, STOPPING.
REQ-022 IDLE -> DECEL on accept if new dirs differ from current dirs and speed != 0; else -> ACCEL.
REQ-023 DECEL: on each tick speed -= RAMP_STEP, saturate at 0; at speed 0 dirs load new values same cycle, -> ACCEL.
REQ-024 ACCEL: on each tick speed moves toward target by RAMP_STEP, no overshoot (clamp to target); at speed == target -> HOLD.
REQ-025 HOLD: count ticks; after dur ticks -> STOPPING; dur 0 -> STOPPING next cycle.
REQ-026 STOPPING: on each tick speed -= RAMP_STEP saturating at 0; at 0 -> IDLE with done pulse.
REQ-027 Dirs shall never change while speed != 0.
REQ-028 speed_l always equals speed_r; both from one speed register.
REQ-029 abort high in ACCEL/HOLD/DECEL -> STOPPING; completion then pulses aborted, not done; abort in IDLE/STOPPING has no effect other than blocking cmd_ready.
REQ-030 done and aborted never both high; each exactly once per accepted command.
REQ-031 Outputs registered; no combinational path from cmd_* to dir/speed.

Reset
REQ-032 rst_n low: state IDLE, speed_l = speed_r = 0, dir_l = dir_r = 1, tick counter 0, busy/done/aborted/cmd_ready 0, all registered command fields 0.
REQ-033 Reset mid-ramp shall drop speeds to 0 immediately and discard the command with no done/aborted pulse.
REQ-034 cmd_ready shall rise on the first clock edge after rst_n deassertion.

Structure
REQ-035 Shared package motion_pkg: op-code constants, state enum type, default NUM_C/RAMP_STEP/MAX_SPEED.
REQ-036 Sub-module period_tick (parameter NUM_C; clk, rst_n in; tick out) instantiated once.

Verification (bench NUM_C=10, RAMP_STEP=500, MAX_SPEED=11000)
REQ-037 FWD speed 2000 dur 3 from reset -> speed 500/1000/1500/2000 on 4 ticks, hold 3 ticks, 4 down-ticks to 0, one done pulse, dirs (1,1) throughout.
REQ-038 FWD 1000 dur 0 then REV 1000 -> second command starts at speed 0, dirs switch to (0,0) only at speed 0, never changed while speed != 0.
REQ-039 FWD 1200 dur 2 -> ramp 500, 1000, 1200 (clamped), no overshoot.
REQ-040 cmd_speed 16000 -> target clamped to 11000.
REQ-041 abort during HOLD at speed 2000 -> ramp 1500..0 over 4 ticks, aborted pulse once, no done, cmd_ready high next cycle.
REQ-042 rst_n low mid-ACCEL asynchronously -> speeds 0, dirs (1,1), busy 0 before next clk edge.
